// File: rtl/fetch_scheduler.sv
// fetch_scheduler: frame fetch sequencer with row-credit throttling and returned-beat tracking.
// Define FETCH_PERF_EN to enable the stall/frame cycle counters; otherwise they read 0.
module fetch_scheduler #(
   parameter int MAX_ROW     = 540,
   parameter int MAX_COL     = 540,
   parameter int CREDIT_ROWS = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   output logic        busy_o,
   output logic        frame_done_o,
   output logic        fetch_run_o,
   input  logic        data_en_i,
   input  logic        row_release_i,
   output logic [2:0]  credit_o,
   output logic [9:0]  row_cnt_o,
   output logic [23:0] stall_cycles_o,
   output logic [23:0] frame_cycles_o,
   output logic        err_o
);
   localparam logic [18:0] TOTAL = 19'(MAX_ROW * MAX_COL);
   localparam logic [2:0]  CR    = 3'(CREDIT_ROWS);

   typedef enum logic [2:0] {IDLE, RUN, STALL, DRAIN, DONE} state_t;
   state_t state, state_nx;

   logic [9:0]  col;
   logic [18:0] beats;
   logic        row_end, last_row;
   logic [2:0]  credit_row;

   always_comb begin
      row_end    = state == RUN && col == 10'(MAX_COL - 1);
      last_row   = row_cnt_o == 10'(MAX_ROW - 1);
      credit_row = row_release_i ? credit_o : credit_o - 3'd1;
   end

   always_ff @(posedge clk)
      state <= !rst_n ? IDLE : state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start_i ? RUN : IDLE;
         RUN:     state_nx = !row_end ? RUN : last_row ? DRAIN : credit_row == 3'd0 ? STALL : RUN;
         STALL:   state_nx = row_release_i ? RUN : STALL;
         DRAIN:   state_nx = beats == TOTAL ? DONE : DRAIN;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb busy_o = state != IDLE;

   // fetch_run_o and frame_done_o are registered from the next state so no input reaches them combinationally
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_run_o  <= 1'b0;
         frame_done_o <= 1'b0;
         credit_o     <= 3'd0;
         row_cnt_o    <= 10'd0;
         err_o        <= 1'b0;
         col          <= 10'd0;
         beats        <= 19'd0;
      end else begin
         fetch_run_o  <= state_nx == RUN;
         frame_done_o <= state_nx == DONE;
         if (state == IDLE) begin
            if (start_i) begin
               credit_o  <= CR;
               row_cnt_o <= 10'd0;
               err_o     <= 1'b0;
               col       <= 10'd0;
               beats     <= 19'd0;
            end else if (data_en_i) begin
               err_o <= 1'b1;
            end
         end else begin
            col       <= row_end ? 10'd0 : state == RUN ? col + 10'd1 : col;
            row_cnt_o <= row_end ? row_cnt_o + 10'd1 : row_cnt_o;
            credit_o  <= row_end ? credit_row : (row_release_i && credit_o != CR) ? credit_o + 3'd1 : credit_o;
            if (row_release_i && !row_end && credit_o == CR)
               err_o <= 1'b1;
            if (data_en_i && state != DONE) begin
               beats <= beats + 19'd1;
               if (beats >= TOTAL)
                  err_o <= 1'b1;
            end
         end
      end
   end

`ifdef FETCH_PERF_EN
   logic [23:0] stall_q, frame_q;
   always_ff @(posedge clk) begin
      if (!rst_n || (state == IDLE && start_i)) begin
         stall_q <= 24'd0;
         frame_q <= 24'd0;
      end else begin
         if (state == STALL && !(&stall_q))
            stall_q <= stall_q + 24'd1;
         if ((state == RUN || state == STALL || state == DRAIN) && !(&frame_q))
            frame_q <= frame_q + 24'd1;
      end
   end
   assign stall_cycles_o = stall_q;
   assign frame_cycles_o = frame_q;
`else
   assign stall_cycles_o = 24'd0;
   assign frame_cycles_o = 24'd0;
`endif
endmodule

// File: tb/tb_fetch_scheduler.sv
// tb_fetch_scheduler: directed scenarios against a pixel/credit-count model of the fetch scheduler.
// Memory controller is modelled as data_en_i = fetch_run_o delayed 3 cycles, cleared with rst_n.
module tb_fetch_scheduler;
   localparam int MR = 4, MC = 5, CR = 2, TOTAL = MR * MC;

   logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, man_rel = 1'b0, auto_rel = 1'b0, auto_en = 1'b0;
   logic data_en_i, row_release_i, busy_o, frame_done_o, fetch_run_o, err_o;
   logic [2:0]  credit_o;
   logic [9:0]  row_cnt_o;
   logic [23:0] stall_cycles_o, frame_cycles_o;
   logic [2:0]  dl = 3'b0;
   logic [15:0] rel_sr = 16'b0;

   int n_vec = 0, n_err = 0;
   int fetch_cnt = 0, done_cnt = 0, base_f = 0, base_d = 0, prev_row = 0, rel_dly = 2;
   int m_busy = 0, m_fetch = 0, m_done = 0, m_credit = 0, m_rows = 0, m_err = 0;
   int m_pix = 0, m_beats = 0, m_stall = 0, m_frame = 0;
   bit m_valid = 0;

   always #5 clk = ~clk;
   assign data_en_i     = dl[2];
   assign row_release_i = man_rel | auto_rel;
   always @(posedge clk) dl <= !rst_n ? 3'b0 : {dl[1:0], fetch_run_o};

   fetch_scheduler #(.MAX_ROW(MR), .MAX_COL(MC), .CREDIT_ROWS(CR)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .busy_o(busy_o), .frame_done_o(frame_done_o),
      .fetch_run_o(fetch_run_o), .data_en_i(data_en_i), .row_release_i(row_release_i),
      .credit_o(credit_o), .row_cnt_o(row_cnt_o), .stall_cycles_o(stall_cycles_o),
      .frame_cycles_o(frame_cycles_o), .err_o(err_o)
   );

   task automatic check(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model counts fetched pixels and returned beats; credits follow the release/row-complete rules.
   task automatic model_step();
      int comp, npix;
      bit nd;
      if (!rst_n) begin
         m_busy = 0; m_fetch = 0; m_done = 0; m_credit = 0; m_rows = 0; m_err = 0;
         m_pix = 0; m_beats = 0; m_stall = 0; m_frame = 0; m_valid = 1;
      end else if (m_busy == 0) begin
         if (start_i) begin
            m_busy = 1; m_fetch = 1; m_credit = CR; m_pix = 0; m_rows = 0;
            m_beats = 0; m_err = 0; m_stall = 0; m_frame = 0;
         end else if (data_en_i) m_err = 1;
      end else begin
         comp = (m_fetch == 1 && (m_pix + 1) % MC == 0) ? 1 : 0;
         if (row_release_i) begin
            if (comp == 0 && m_credit == CR) m_err = 1;
            else m_credit++;
         end
         m_credit -= comp;
         if (m_done == 1) begin
            m_done = 0; m_busy = 0;
         end else begin
            nd = m_fetch == 0 && m_pix == TOTAL && m_beats == TOTAL;
            if (m_fetch == 0 && m_pix < TOTAL) m_stall++;
            m_frame++;
            if (data_en_i) begin
               if (m_beats >= TOTAL) m_err = 1;
               m_beats++;
            end
            npix = m_pix + m_fetch;
            m_rows += comp;
            m_pix = npix;
            m_fetch = (npix < TOTAL && (npix % MC != 0 || m_credit > 0)) ? 1 : 0;
            m_done = nd ? 1 : 0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      if (m_valid) begin
         check("fetch_run", int'(fetch_run_o), m_fetch);
         check("busy", int'(busy_o), m_busy);
         check("frame_done", int'(frame_done_o), m_done);
         check("credit", int'(credit_o), m_credit);
         check("row_cnt", int'(row_cnt_o), m_rows);
         check("err", int'(err_o), m_err);
`ifdef FETCH_PERF_EN
         check("stall_cycles", int'(stall_cycles_o), m_stall);
         check("frame_cycles", int'(frame_cycles_o), m_frame);
`else
         check("stall_cycles", int'(stall_cycles_o), 0);
         check("frame_cycles", int'(frame_cycles_o), 0);
`endif
      end
      fetch_cnt += int'(fetch_run_o);
      done_cnt  += int'(frame_done_o);
      rel_sr = {rel_sr[14:0], int'(row_cnt_o) > prev_row};
      prev_row = int'(row_cnt_o);
      auto_rel = auto_en & rel_sr[rel_dly-1];
   endtask

   task automatic frame_start();
      start_i = 1'b1;
      base_f = fetch_cnt;
      base_d = done_cnt;
      tick();
      start_i = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      // credit-limited stall with no releases
      frame_start();
      repeat (19) tick();
      check("s1_fetches", fetch_cnt - base_f, 10);
      check("s1_credit", int'(credit_o), 0);
      check("s1_row_cnt", int'(row_cnt_o), 2);
      check("s1_no_done", done_cnt - base_d, 0);
      check("s1_busy", int'(busy_o), 1);
      // full frame with releases two cycles after each row
      do_reset();
      auto_en = 1'b1;
      rel_dly = 2;
      frame_start();
      repeat (35) tick();
      check("s2_fetches", fetch_cnt - base_f, 20);
      check("s2_done_pulses", done_cnt - base_d, 1);
      check("s2_err", int'(err_o), 0);
      check("s2_busy", int'(busy_o), 0);
      check("s2_credit", int'(credit_o), 2);
`ifdef FETCH_PERF_EN
      check("s2_frame_cycles", int'(frame_cycles_o), 24);
`endif
      // release coincident with row completion, then over-release and ignored start
      auto_en = 1'b0;
      frame_start();
      repeat (9) tick();
      man_rel = 1'b1;
      tick();
      man_rel = 1'b0;
      check("s3_no_bubble", int'(fetch_run_o), 1);
      check("s3_credit", int'(credit_o), 1);
      check("s3_row_cnt", int'(row_cnt_o), 2);
      repeat (5) tick();
      check("s4_stalled", int'(fetch_run_o), 0);
      check("s4_stall_credit", int'(credit_o), 0);
      man_rel = 1'b1;
      tick();
      man_rel = 1'b0;
      tick();
      man_rel = 1'b1;
      repeat (2) tick();
      man_rel = 1'b0;
      check("s4_err", int'(err_o), 1);
      check("s4_credit_sat", int'(credit_o), 2);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      repeat (15) tick();
      check("s4_fetches", fetch_cnt - base_f, 20);
      check("s4_done_pulses", done_cnt - base_d, 1);
      check("s4_err_sticky", int'(err_o), 1);
      // reset mid-row, then a full frame with slow releases that stall
      frame_start();
      repeat (3) tick();
      do_reset();
      check("s5_fetch", int'(fetch_run_o), 0);
      check("s5_busy", int'(busy_o), 0);
      check("s5_credit", int'(credit_o), 0);
      check("s5_row_cnt", int'(row_cnt_o), 0);
      auto_en = 1'b1;
      rel_dly = 8;
      frame_start();
      repeat (80) tick();
      check("s5_fetches", fetch_cnt - base_f, 20);
      check("s5_done_pulses", done_cnt - base_d, 1);
      check("s5_err", int'(err_o), 0);
      check("s5_busy", int'(busy_o), 0);
`ifdef FETCH_PERF_EN
      check("s5_stall_cycles", int'(stall_cycles_o), 3);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/fetch_scheduler.md
Name: fetch_scheduler

Overview:
Frame-level sequencer for the BRAM memory controller. It drives the controller's fetch-run input one pixel per cycle, and it throttles row fetches with a credit scheme fed by the downstream line buffer/preprocess stage. It also tracks returned pixel beats so it can signal end of frame. It sits between the top-level controller (start/done) and the memory controller.

Parameters:
MAX_ROW, 540, image rows per frame
MAX_COL, 540, pixels per row
CREDIT_ROWS, 3, row slots available in the downstream line buffer (1..7)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
start_i  input  1  start-frame pulse; ignored unless idle
busy_o  output  1  high in any state other than IDLE
frame_done_o  output  1  one-cycle pulse when the last pixel beat has returned
fetch_run_o  output  1  to memory controller fetch-run input; each high cycle fetches one pixel
data_en_i  input  1  returned-pixel valid from memory controller (3-cycle latency from fetch_run_o)
row_release_i  input  1  pulse: consumer freed one row slot
credit_o  output  3  current free row credits
row_cnt_o  output  10  rows issued so far in the current frame
stall_cycles_o  output  24  optional perf counter (see Optional Feature)
frame_cycles_o  output  24  optional perf counter
err_o  output  1  sticky protocol error flag

Behaviour:
- Reset and clocking: rst_n is synchronous, active-low; clock is clk. All state is clocked.
- Reset values: state=IDLE; fetch_run_o=0; busy_o=0; frame_done_o=0; credit_o=0; row_cnt_o=0; err_o=0; perf counters=0.
- fetch_run_o is driven directly from a flop; there is no combinational path from any input.
- States: IDLE, RUN, STALL, DRAIN, DONE.
- IDLE:
  - start_i=1 → RUN next cycle.
  - On that transition: credit=CREDIT_ROWS; col, row and beat counters cleared; err_o cleared.
- RUN:
  - fetch_run_o=1 and the column counter increments every cycle.
  - At col==MAX_COL-1 the row is complete: col←0, row_cnt+1, credit−1 (+1 if row_release_i is high in the same cycle, net 0).
  - Row complete and it was row MAX_ROW-1 → DRAIN.
  - Otherwise, row complete and the updated credit==0 → STALL.
  - Otherwise stay in RUN; fetch continues back-to-back with no bubble.
- STALL:
  - fetch_run_o=0.
  - row_release_i → credit+1 and RUN next cycle, resuming at col 0 of the next row.
- DRAIN:
  - fetch_run_o=0.
  - Wait until the beat counter reaches MAX_ROW*MAX_COL, then → DONE.
- DONE: frame_done_o=1 for exactly one cycle, then → IDLE.
- Beat counter: 19 bits; increments on every data_en_i in RUN, STALL or DRAIN.
- Credit accounting:
  - Credits are tracked in every non-IDLE state.
  - A release when credit==CREDIT_ROWS (with no row completing that cycle) sets err_o; credit saturates.
  - row_release_i in IDLE is ignored.
- err_o is also set by:
  - data_en_i while IDLE;
  - beat counter exceeding MAX_ROW*MAX_COL.
- Cycle-accuracy invariant: the total number of fetch_run_o high cycles per frame equals MAX_ROW*MAX_COL exactly. The memory controller's address and row/col counters stay frame-aligned only because of this.
- start_i while busy_o=1 is ignored; it is not queued.
- Reset asserted mid-frame returns everything to reset values in the next cycle. The memory controller must be reset together with this block.
- Latency: start_i at cycle 0 → fetch_run_o high at cycle 1. Last data_en_i at cycle N → frame_done_o at cycle N+2 (one cycle to DONE, one cycle of pulse registration).

Optional Feature:
FETCH_PERF_EN
- Defined:
  - stall_cycles_o counts cycles spent in STALL.
  - frame_cycles_o counts cycles from leaving IDLE to reaching DONE.
  - Both are cleared on the start transition, saturate at all-ones, and hold their value after DONE until the next start.
- Undefined: both outputs are tied to 0 and no counter logic is instantiated.

Test Plan:
Bench configuration: MAX_ROW=4, MAX_COL=5, CREDIT_ROWS=2. The bench models the memory controller as data_en_i = fetch_run_o delayed 3 cycles.
1. Credit-limited stall: start, never release → rows 0–1 issued; fetch_run_o high for 10 cycles; state STALL with credit_o=0; row_cnt_o=2; no frame_done_o.
2. Release each row 2 cycles after it completes → 20 fetch_run_o cycles in total; frame_done_o pulses exactly once; busy_o falls on the following cycle; err_o=0.
3. row_release_i coincident with a row completion at credit=1 → credit_o stays 1 and there is no stall bubble between rows.
4. Extra release at credit_o=2 → err_o=1 and credit_o stays 2. A second start_i pulse while busy → no effect.
5. rst_n low for 1 cycle mid-row (col=3) → next cycle fetch_run_o=0, state IDLE, credit_o=0, row_cnt_o=0. A new start then completes a full 20-beat frame.
6. FETCH_PERF_EN defined, scenario 2 stimulus → stall_cycles_o equals the summed stall durations and frame_cycles_o equals total busy cycles minus 1. Undefined → both read 0.
